// File: rtl/test_status_pkg.sv
// rtl/test_status_pkg.sv - shared types and helpers for the test status monitor
package test_status_pkg;

  // Final verdict held by the monitor
  typedef enum logic [1:0] {
    NONE,
    PASS,
    FAIL,
    TIMEOUT
  } verdict_e;

  // Classification of one snooped write
  typedef enum logic [1:0] {
    IGNORE,
    HIT_PASS,
    HIT_FAIL
  } decode_e;

  // Global monitor state
  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE
  } state_e;

  // Width of the failing-core index; a single core still gets one bit
  function automatic int fail_core_width(input int ncores);
    return (ncores <= 1) ? 1 : $clog2(ncores);
  endfunction

endpackage

// File: rtl/tohost_decode.sv
// rtl/tohost_decode.sv - combinational tohost hit detect and decode for one core
module tohost_decode
  import test_status_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                XLEN        = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h1000
) (
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   data_i,
  output decode_e           kind_o,
  output logic [XLEN-2:0]   code_o
);

  logic hit;

  assign hit    = valid_i && (addr_i == TOHOST_ADDR);
  assign code_o = data_i[XLEN-1:1];

  // 1 means pass, other odd values carry a fail code, even values belong to the host
  always_comb begin
    kind_o = IGNORE;
    if (hit) begin
      if (data_i == XLEN'(1)) begin
        kind_o = HIT_PASS;
      end else if (data_i[0]) begin
        kind_o = HIT_FAIL;
      end
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// rtl/test_status_monitor.sv - N-core tohost pass/fail monitor with cycle watchdog
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter int                NCORES      = 1,
  parameter int                XLEN        = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h1000,
  parameter int                CYCLE_W     = 64,
  parameter int                HOLD_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NCORES-1:0]                  wr_valid,
  input  logic [NCORES*ADDR_W-1:0]           wr_addr,
  input  logic [NCORES*XLEN-1:0]             wr_data,
  input  logic [CYCLE_W-1:0]                 max_cycles,
  output logic                               done,
  output logic                               pass,
  output logic                               fail,
  output logic                               timeout,
  output logic [XLEN-2:0]                    fail_code,
  output logic [fail_core_width(NCORES)-1:0] fail_core,
  output logic [NCORES-1:0]                  finished,
  output logic [CYCLE_W-1:0]                 cycle_count
);

  localparam int FC_W   = fail_core_width(NCORES);
  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CYCLE_W-1:0]  cnt_q, cnt_d;
  logic [NCORES-1:0]   fin_q, fin_d;
  verdict_e            verdict_q, verdict_d;
  logic [XLEN-2:0]     code_q, code_d;
  logic [FC_W-1:0]     core_q, core_d;

  decode_e             kind [NCORES];
  logic [XLEN-2:0]     code [NCORES];

  logic                fail_hit;
  logic [FC_W-1:0]     fail_idx;
  logic [XLEN-2:0]     fail_val;
  logic [NCORES-1:0]   fin_hit;
  verdict_e            verdict_now;

  for (genvar g = 0; g < NCORES; g++) begin : g_dec
    tohost_decode #(
      .ADDR_W      (ADDR_W),
      .XLEN        (XLEN),
      .TOHOST_ADDR (TOHOST_ADDR)
    ) u_dec (
      .valid_i (wr_valid[g]),
      .addr_i  (wr_addr[g*ADDR_W +: ADDR_W]),
      .data_i  (wr_data[g*XLEN +: XLEN]),
      .kind_o  (kind[g]),
      .code_o  (code[g])
    );
  end

  // Arbitrate this cycle's hits: lowest failing core, then full pass mask, then watchdog
  always_comb begin
    fail_hit    = 1'b0;
    fail_idx    = '0;
    fail_val    = '0;
    fin_hit     = fin_q;
    verdict_now = NONE;
    // Walk downwards so the lowest failing index is the one left standing
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (kind[i] == HIT_PASS) begin
        fin_hit[i] = 1'b1;
      end
      if (kind[i] == HIT_FAIL) begin
        fail_hit = 1'b1;
        fail_idx = FC_W'(i);
        fail_val = code[i];
      end
    end
    if (fail_hit) begin
      verdict_now = FAIL;
    end else if (&fin_hit) begin
      verdict_now = PASS;
    end else if ((max_cycles != '0) && (cnt_q > max_cycles)) begin
      verdict_now = TIMEOUT;
    end
  end

  // Next state: hold countdown, evaluation in RUN, sticky verdict in DONE
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    fin_d     = fin_q;
    verdict_d = verdict_q;
    code_d    = code_q;
    core_d    = core_q;
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CYCLE_W'(1);
    case (state_q)
      S_HOLD: begin
        // The cycle in which the counter drops to zero is the last masked one
        if (hold_q <= HOLD_W'(1)) begin
          hold_d  = '0;
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_RUN: begin
        fin_d = fin_hit;
        if (verdict_now != NONE) begin
          state_d   = S_DONE;
          verdict_d = verdict_now;
          if (verdict_now == FAIL) begin
            code_d = fail_val;
            core_d = fail_idx;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HOLD;
      hold_q    <= HOLD_W'(HOLD_CYCLES);
      cnt_q     <= '0;
      fin_q     <= '0;
      verdict_q <= NONE;
      code_q    <= '0;
      core_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      fin_q     <= fin_d;
      verdict_q <= verdict_d;
      code_q    <= code_d;
      core_q    <= core_d;
    end
  end

  assign done        = (verdict_q != NONE);
  assign pass        = (verdict_q == PASS);
  assign fail        = (verdict_q == FAIL);
  assign timeout     = (verdict_q == TIMEOUT);
  assign fail_code   = code_q;
  assign fail_core   = core_q;
  assign finished    = fin_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// tb/tb_test_status_monitor.sv - self-checking bench for the test status monitor
module tb_test_status_monitor;

  localparam logic [31:0] TOHOST    = 32'h1000;
  localparam int          HOLD_MASK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Single-core instance
  logic        r1 = 1'b1;
  logic [0:0]  v1 = '0;
  logic [31:0] a1 = '0, d1 = '0;
  logic [63:0] m1 = '0;
  logic        o1_done, o1_pass, o1_fail, o1_to;
  logic [30:0] o1_code;
  logic [0:0]  o1_core, o1_fin;
  logic [63:0] o1_cnt;

  // Four-core instance
  logic         r4 = 1'b1;
  logic [3:0]   v4 = '0;
  logic [127:0] a4 = '0, d4 = '0;
  logic [63:0]  m4 = '0;
  logic         o4_done, o4_pass, o4_fail, o4_to;
  logic [30:0]  o4_code;
  logic [1:0]   o4_core;
  logic [3:0]   o4_fin;
  logic [63:0]  o4_cnt;

  test_status_monitor #(.NCORES(1)) u1 (
    .clk(clk), .reset(r1), .wr_valid(v1), .wr_addr(a1), .wr_data(d1), .max_cycles(m1),
    .done(o1_done), .pass(o1_pass), .fail(o1_fail), .timeout(o1_to),
    .fail_code(o1_code), .fail_core(o1_core), .finished(o1_fin), .cycle_count(o1_cnt)
  );

  test_status_monitor #(.NCORES(4)) u4 (
    .clk(clk), .reset(r4), .wr_valid(v4), .wr_addr(a4), .wr_data(d4), .max_cycles(m4),
    .done(o4_done), .pass(o4_pass), .fail(o4_fail), .timeout(o4_to),
    .fail_code(o4_code), .fail_core(o4_core), .finished(o4_fin), .cycle_count(o4_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          idle;
    bit          rst;
    bit          v;
    logic [31:0] addr;
    logic [31:0] data;
    logic [63:0] mx;
    bit          e_done, e_pass, e_fail, e_to;
    logic [30:0] e_code;
  } vec_t;

  function automatic vec_t mk(int idle, bit rst, bit v, logic [31:0] addr, logic [31:0] data,
                              logic [63:0] mx, bit ed, bit ep, bit ef, bit et, logic [30:0] ec);
    vec_t t;
    t.idle = idle; t.rst = rst; t.v = v; t.addr = addr; t.data = data; t.mx = mx;
    t.e_done = ed; t.e_pass = ep; t.e_fail = ef; t.e_to = et; t.e_code = ec;
    return t;
  endfunction

  // Reference model for the four-core instance: cycles since reset, pass set, verdict
  logic [63:0] m_cnt;
  bit          m_done, m_pass, m_fail, m_to;
  logic [30:0] m_code;
  logic [1:0]  m_core;
  logic [3:0]  m_fin;

  task automatic model_step(input bit rst, input logic [3:0] v, input logic [127:0] a,
                            input logic [127:0] d, input logic [63:0] mx);
    bit          fseen;
    logic [3:0]  nf;
    logic [31:0] di;
    if (rst) begin
      m_cnt = 0; m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
      m_code = 0; m_core = 0; m_fin = 0;
      return;
    end
    // The first HOLD_MASK cycles after reset are blind to writes
    if (!m_done && (m_cnt + 1 > HOLD_MASK)) begin
      fseen = 0;
      nf    = m_fin;
      for (int i = 0; i < 4; i++) begin
        di = d[i*32 +: 32];
        if (v[i] && a[i*32 +: 32] == TOHOST) begin
          if (di == 1) nf[i] = 1'b1;
          else if ((di % 2 == 1) && !fseen) begin
            fseen  = 1;
            m_code = 31'(di / 2);
            m_core = 2'(i);
          end
        end
      end
      m_fin = nf;
      if (fseen) begin
        m_done = 1; m_fail = 1;
      end else if (nf == 4'hf) begin
        m_done = 1; m_pass = 1;
      end else if (mx != 0 && m_cnt > mx) begin
        m_done = 1; m_to = 1;
      end
    end
    m_cnt = m_cnt + 1;
  endtask

  task automatic step4(input bit rst, input logic [3:0] v, input logic [127:0] a,
                       input logic [127:0] d, input logic [63:0] mx);
    r4 = rst; v4 = v; a4 = a; d4 = d; m4 = mx;
    tick();
    model_step(rst, v, a, d, mx);
    chk("u4 model", 128'({o4_done, o4_pass, o4_fail, o4_to, o4_code, o4_core, o4_fin, o4_cnt}),
        128'({m_done, m_pass, m_fail, m_to, m_code, m_core, m_fin, m_cnt}));
  endtask

  vec_t         tbl[$];
  logic [63:0]  cnt;
  logic [127:0] all_tohost;
  logic [127:0] rd, ra;
  logic [3:0]   rv;
  logic [63:0]  rmx;
  logic [31:0]  tmp;
  bit           rr;
  int           sel;

  initial begin
    // idle, rst, v, addr, data, max, done, pass, fail, timeout, code
    tbl.push_back(mk(0,     1, 0, TOHOST,       0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,     0, 1, TOHOST,       1, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,     0, 1, TOHOST,       1, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(47,    0, 1, TOHOST,       1, 0,   1, 1, 0, 0, 0));
    tbl.push_back(mk(0,     0, 1, TOHOST,       7, 0,   1, 1, 0, 0, 0));
    tbl.push_back(mk(0,     1, 0, TOHOST,       0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(5,     0, 1, 32'h1004,     1, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,     0, 1, TOHOST,       2, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,     0, 1, TOHOST,       0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,     0, 1, TOHOST,       7, 0,   1, 0, 1, 0, 3));
    tbl.push_back(mk(0,     0, 1, TOHOST,       1, 0,   1, 0, 1, 0, 3));
    tbl.push_back(mk(0,     1, 0, TOHOST,       0, 100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(100,   0, 0, TOHOST,       0, 100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,     0, 0, TOHOST,       0, 100, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0,     1, 0, TOHOST,       0, 100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(100,   0, 0, TOHOST,       0, 100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,     0, 1, TOHOST,       1, 100, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0,     1, 0, TOHOST,       0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(10,    0, 1, TOHOST,       1, 0,   1, 1, 0, 0, 0));
    tbl.push_back(mk(0,     1, 0, TOHOST,       0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(10000, 0, 0, TOHOST,       0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,     0, 0, TOHOST,       0, 50,  1, 0, 0, 1, 0));

    cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      r1 = 1'b0; v1 = 1'b0; m1 = tbl[i].mx;
      for (int k = 0; k < tbl[i].idle; k++) tick();
      r1 = tbl[i].rst; v1 = tbl[i].v; a1 = tbl[i].addr; d1 = tbl[i].data;
      tick();
      cnt = tbl[i].rst ? 64'd0 : cnt + 64'(tbl[i].idle) + 64'd1;
      chk($sformatf("u1 vec%0d", i),
          128'({o1_done, o1_pass, o1_fail, o1_to, o1_code, o1_core, o1_fin, o1_cnt}),
          128'({tbl[i].e_done, tbl[i].e_pass, tbl[i].e_fail, tbl[i].e_to, tbl[i].e_code,
                1'b0, tbl[i].e_pass, cnt}));
    end
    r1 = 1'b1; v1 = 1'b0;

    all_tohost = {4{TOHOST}};

    // Cores 0, 2, 3 pass early; core 1 completes the mask at cycle 200
    step4(1, 4'b0000, all_tohost, '0, 64'd0);
    step4(0, 4'b0000, all_tohost, '0, 64'd0);
    step4(0, 4'b0000, all_tohost, '0, 64'd0);
    step4(0, 4'b1101, all_tohost, {32'h1, 32'h1, 32'h0, 32'h1}, 64'd0);
    chk("u4 partial mask", 128'({o4_done, o4_fin}), 128'({1'b0, 4'b1101}));
    for (int k = 4; k < 200; k++) step4(0, 4'b0000, all_tohost, '0, 64'd0);
    chk("u4 before core1", 128'(o4_done), 128'(1'b0));
    step4(0, 4'b0010, all_tohost, {32'h0, 32'h0, 32'h1, 32'h0}, 64'd0);
    chk("u4 pass after core1", 128'({o4_done, o4_pass, o4_fail, o4_to, o4_fin}),
        128'({4'b1100, 4'b1111}));

    // Cores 2 and 1 fail together; lower index wins
    step4(1, 4'b0000, all_tohost, '0, 64'd0);
    step4(0, 4'b0000, all_tohost, '0, 64'd0);
    step4(0, 4'b0000, all_tohost, '0, 64'd0);
    step4(0, 4'b0110, all_tohost, {32'h0, 32'h5, 32'h9, 32'h0}, 64'd0);
    chk("u4 simultaneous fail", 128'({o4_done, o4_pass, o4_fail, o4_to, o4_core, o4_code}),
        128'({4'b1010, 2'd1, 31'd4}));

    // Randomized run against the model, with resets after verdicts and mid-run
    rmx = 64'd50;
    for (int n = 0; n < 4000; n++) begin
      rr = (m_done && $urandom_range(0, 3) == 0) || ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0)
        rmx = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(5, 120));
      for (int i = 0; i < 4; i++) begin
        rv[i] = ($urandom_range(0, 19) == 0);
        sel = $urandom_range(0, 7);
        tmp = $urandom;
        ra[i*32 +: 32] = (sel < 6) ? TOHOST : ((sel == 6) ? 32'h1004 : tmp);
        sel = $urandom_range(0, 19);
        tmp = $urandom;
        if (sel < 12) tmp = 32'h1;
        else if (sel < 14) tmp = 32'h0;
        else if (sel < 17) tmp[0] = 1'b0;
        else begin
          tmp[0] = 1'b1;
          if (tmp == 32'h1) tmp = 32'h3;
        end
        rd[i*32 +: 32] = tmp;
      end
      step4(rr, rv, ra, rd, rmx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Parametrised pass/fail monitor for simulation harnesses; generalises single-core tohost polling to N cores, with a programmable tohost address and a cycle-limit watchdog.
- Snoops each core's data-memory write port and detects writes to the tohost word.
- Emits a sticky verdict (pass / fail code / timeout) that the harness uses to end the run.
- Sits beside the DUT top in the test harness; does not drive any DUT input.

Parameters:
- NCORES, 1, number of snooped cores/channels (1..16)
- XLEN, 32, width of the tohost data word
- ADDR_W, 32, width of the snooped byte address
- TOHOST_ADDR, 32'h1000, byte address of tohost; word-aligned
- CYCLE_W, 64, width of the cycle counter and the limit
- HOLD_CYCLES, 2, cycles after reset deassertion during which snooped writes are masked

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  NCORES  per-core write strobe
- wr_addr  in  NCORES*ADDR_W  per-core byte address; core i uses slice i
- wr_data  in  NCORES*XLEN  per-core write data
- max_cycles  in  CYCLE_W  cycle limit; 0 disables the watchdog
- done  out  1  sticky; verdict valid
- pass  out  1  all cores wrote 1
- fail  out  1  some core wrote an odd value other than 1
- timeout  out  1  watchdog expired
- fail_code  out  XLEN-1  data>>1 of the first failing write
- fail_core  out  $clog2(NCORES) (min 1)  index of the failing core
- finished  out  NCORES  per-core pass mask
- cycle_count  out  CYCLE_W  cycles since reset deassertion

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any cycle, including mid-run or after done): all outputs 0; state goes to HOLD; hold counter loads HOLD_CYCLES.
- cycle_count increments every non-reset cycle from 0 and saturates at all-ones.
- Global state machine:
  - HOLD: all writes ignored. Move to RUN when the hold counter reaches 0. With HOLD_CYCLES=0, enter RUN on the first cycle after reset.
  - RUN: evaluate tohost writes and the watchdog.
  - DONE: sticky until reset; all further writes are ignored.
- Tohost hit for core i: wr_valid[i] is high and wr_addr[i] equals TOHOST_ADDR exactly (full compare).
- Decode of a hit in RUN:
  - data==1: set finished[i]. A repeated pass from the same core has no effect.
  - data odd and not 1: failure, code = data>>1.
  - data==0 or even: ignored (reserved for host syscalls).
- Same-cycle priority:
  1. Any failure wins. Among simultaneous failures, the lowest core index wins.
  2. Otherwise, if the finished mask including this cycle's hits is all ones: pass.
  3. Otherwise, if max_cycles != 0 and cycle_count > max_cycles: timeout.
- A failure or pass that lands in the same cycle as timeout expiry takes precedence over the timeout.
- Verdict outputs register one cycle after the deciding write or count: done and exactly one of pass/fail/timeout rise together. fail_code and fail_core are valid only when fail=1 and are 0 otherwise.
- A core that already passed and later writes a failure value still causes fail.
- max_cycles is sampled every cycle, so changing it mid-run takes effect immediately.

Decomposition:
- Package test_status_pkg holds:
  - verdict enum: NONE, PASS, FAIL, TIMEOUT
  - the tohost decode enum: IGNORE, HIT_PASS, HIT_FAIL
  - a function computing the fail_core width
- Sub-module tohost_decode, one instance per core: combinational hit/decode of one channel. Outputs the decode enum and the fail code.
- The top level holds the FSM, the counters and the priority arbitration.

Test Plan:
- NCORES=1: core 0 writes 32'h1 to 0x1000 at cycle 50 -> done=pass=1 at cycle 51; fail=timeout=0.
- NCORES=1: core writes 32'h7 -> fail=1, fail_code=3, fail_core=0. A later write of 32'h1 does not change the verdict.
- NCORES=4: cores 0, 2 and 3 pass early; core 1 passes at cycle 200 -> pass only after core 1; finished walks 4'b1101 -> 4'b1111.
- NCORES=4: cores 2 and 1 write 32'h5 and 32'h9 in the same cycle -> fail_core=1, fail_code=4.
- max_cycles=100 with no writes -> timeout=1 at count 101. max_cycles=0 -> never times out in 10k cycles. A pass write at the expiry cycle -> pass, not timeout.
- Boundary cases:
  - Write during HOLD, to 0x1004, or with data 32'h2 -> ignored.
  - Reset asserted for 1 cycle after done -> all outputs 0 next cycle; a fresh run completes.
